cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
Control stage directly upstream of datapath. It holds the instruction register, decodes fields and immediates, and runs a Moore FSM that sequences the datapath control inputs: readnum, writenum, write, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, sximm5 and sximm8. Supported instructions are MOV imm, MOV reg, ADD, CMP, AND and MVN. Start and done use an s/w handshake to the top level.

Parameters:
DATA_W, 16, instruction and immediate width; the datapath is fixed at 16, so any other value is unsupported.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
in  in  16  instruction word
load_ir  in  1  capture in into IR; honoured only while w=1
s  in  1  start the instruction held in IR; sampled only while w=1
w  out  1  high = idle, ready for load_ir/s
illegal  out  1  one-cycle pulse on an undefined opcode/op
readnum  out  3  register file read index
writenum  out  3  register file write index
write  out  1  register file write enable
vsel  out  4  one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
loada  out  1  load A
loadb  out  1  load B
asel  out  1  1 = ALU A input forced to 0
bsel  out  1  1 = ALU B input is sximm5
shift  out  2  shifter op, IR[4:3]
ALUop  out  2  00 add, 01 sub, 10 and, 11 not B
loadc  out  1  load C
loads  out  1  load status (Z/N/V)
sximm5  out  16  sign-extended IR[4:0]
sximm8  out  16  sign-extended IR[7:0]

Behaviour:
- IR fields: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0].
- Encodings: MOV imm = 110/10; MOV reg = 110/00; ALU ops = 101/xx, with op giving ALUop (00 ADD, 01 CMP, 10 AND, 11 MVN).
- sximm5, sximm8 and shift are combinational from IR.
- All control outputs are a Moore decode of the state plus IR. Any control not listed for a state is 0.
- Reset (reset_n=0, async):
  - state=S_WAIT, IR=0.
  - w=1; every other output is 0, including sximm5/sximm8, which follow IR=0.
- S_WAIT:
  - w=1.
  - load_ir=1 captures in at the edge.
  - s=1 moves to S_DECODE. If load_ir and s are both high in the same cycle, the newly captured word is the one executed.
- S_DECODE, no outputs asserted:
  - MOV imm → S_WRITE_IMM.
  - MOV reg or MVN → S_GET_B.
  - ADD, CMP or AND → S_GET_A.
  - Anything else → S_WAIT, with illegal=1 for that cycle.
- S_GET_A: readnum=Rn, loada=1 → S_GET_B.
- S_GET_B: readnum=Rm, loadb=1 → S_ALU.
- S_ALU:
  - shift=sh, ALUop=op, loadc=1. MOV reg forces asel=1 and ALUop=00.
  - CMP: loads=1, loadc=0 → S_WAIT.
  - All others → S_WRITE_RD.
- S_WRITE_RD: writenum=Rd, vsel=0001, write=1 → S_WAIT.
- S_WRITE_IMM: writenum=Rn, vsel=0100, write=1 → S_WAIT.
- Latency, s-edge to w=1:
  - MOV imm: 2 cycles.
  - MOV reg, MVN, CMP: 4 cycles (CMP is DECODE, GET_A, GET_B, ALU).
  - ADD, AND: 5 cycles.
- Edge cases:
  - Reset mid-instruction aborts immediately; no write is issued afterwards.
  - load_ir and s are ignored while w=0. IR is stable for the whole instruction.
  - bsel stays 0 for every supported instruction, but sximm5 is still driven.

Decomposition:
- Package cpu_pkg holds:
  - the state enum;
  - opcode/op constants;
  - VSEL_MDATA/SXIMM8/PC/C one-hot constants;
  - ALUop constants.
- Sub-module cpu_inst_decoder is purely combinational: IR → fields, sximm5, sximm8, instruction class. The FSM and IR live in cpu_controller.

Test Plan:
- Reset, then MOV R1,#7: load_ir+s with in=16'hD107.
  - DECODE, then WRITE_IMM with writenum=1, vsel=0100, write=1, sximm8=16'h0007.
  - w=1 after 2 edges.
- MOV R2,#-16: in=16'hD2F0.
  - sximm8=16'hFFF0, writenum=2 in WRITE_IMM.
- ADD R2,R1,R0 LSL1: in=16'hA148.
  - GET_A: readnum=1, loada.
  - GET_B: readnum=0, loadb.
  - ALU: shift=01, ALUop=00, asel=0, loadc.
  - WRITE_RD: writenum=2, vsel=0001, write.
  - w=1 after 5 edges.
- CMP R1,R0: in=16'hA900.
  - ALU cycle: ALUop=01, loads=1, loadc=0.
  - No write pulse at any point; back to WAIT after 4 edges.
- Illegal word: in=16'hE000.
  - illegal=1 for exactly one cycle, no write, w=1 two edges after s.
- Reset mid-op: drop reset_n during GET_B of ADD.
  - Outputs clear asynchronously, w=1.
  - After release, s with the new IR executes correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU control stage: FSM states,
// instruction classes, opcode/op fields, writeback selects and ALU ops.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_RD,
    S_WRITE_IMM
  } state_t;

  typedef enum logic [2:0] {
    C_MOV_IMM,
    C_MOV_REG,
    C_ADD,
    C_CMP,
    C_AND,
    C_MVN,
    C_ILLEGAL
  } inst_class_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_PC     = 4'b0010;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  function automatic inst_class_t classify(input logic [2:0] opcode, input logic [1:0] op);
    inst_class_t c;
    c = C_ILLEGAL;
    if (opcode == OPC_MOV && op == OP_MOV_IMM) c = C_MOV_IMM;
    else if (opcode == OPC_MOV && op == OP_MOV_REG) c = C_MOV_REG;
    else if (opcode == OPC_ALU) begin
      case (op)
        ALU_ADD: c = C_ADD;
        ALU_SUB: c = C_CMP;
        ALU_AND: c = C_AND;
        default: c = C_MVN;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/cpu_inst_decoder.sv
// Combinational instruction decoder: splits the IR into register fields,
// sign-extended immediates and an instruction class for the FSM.
module cpu_inst_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [2:0]        rm,
  output logic [1:0]        sh,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output inst_class_t       cls
);

  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign sh     = ir[4:3];
  assign op     = ir[12:11];
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign cls    = classify(ir[15:13], ir[12:11]);

endmodule

// File: rtl/cpu_controller.sv
// Control stage: instruction register plus a Moore FSM that sequences the
// datapath controls for MOV imm/reg, ADD, CMP, AND and MVN.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load_ir,
  input  logic              s,
  output logic              w,
  output logic              illegal,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic [3:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  state_t            state, next_state;
  logic [DATA_W-1:0] ir;
  logic [2:0]        rn, rd, rm;
  logic [1:0]        sh, op;
  inst_class_t       cls;

  cpu_inst_decoder #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .op     (op),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  assign shift = sh;

  // IR only moves while idle, so it is stable for the whole instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_WAIT && load_ir) ir <= in;
    end
  end

  always_comb begin
    next_state = state;
    w          = 1'b0;
    illegal    = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    write      = 1'b0;
    vsel       = 4'b0000;
    loada      = 1'b0;
    loadb      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    ALUop      = ALU_ADD;
    loadc      = 1'b0;
    loads      = 1'b0;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          C_MOV_IMM:           next_state = S_WRITE_IMM;
          C_MOV_REG, C_MVN:    next_state = S_GET_B;
          C_ADD, C_CMP, C_AND: next_state = S_GET_A;
          default: begin
            illegal    = 1'b1;
            next_state = S_WAIT;
          end
        endcase
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = S_ALU;
      end
      S_ALU: begin
        ALUop = op;
        if (cls == C_MOV_REG) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end
        // CMP only updates status flags and never writes back
        if (cls == C_CMP) begin
          loads      = 1'b1;
          next_state = S_WAIT;
        end else begin
          loadc      = 1'b1;
          next_state = S_WRITE_RD;
        end
      end
      S_WRITE_RD: begin
        writenum   = rd;
        vsel       = VSEL_C;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum   = rn;
        vsel       = VSEL_SXIMM8;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-instruction expected output
// sequences from a queue model, plus directed literal checks.
module tb_cpu_controller;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        load_ir = 1'b0;
  logic        s = 1'b0;
  logic        w, illegal, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic [1:0]  shift, aluop;
  logic [15:0] sximm5, sximm8;

  int n_vec = 0;
  int n_err = 0;

  exp_t        q[$];
  logic [15:0] m_ir = '0;
  exp_t        act;

  cpu_controller #(.DATA_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (instr),
    .load_ir  (load_ir),
    .s        (s),
    .w        (w),
    .illegal  (illegal),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (aluop),
    .loadc    (loadc),
    .loads    (loads),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

  always #5 clk = ~clk;

  assign act = {w, illegal, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
                shift, aluop, loadc, loads, sximm5, sximm8};

  function automatic exp_t idleOf(input logic [15:0] ir);
    exp_t e;
    e        = '0;
    e.w      = 1'b1;
    e.shift  = ir[4:3];
    e.sximm5 = {{11{ir[4]}}, ir[4:0]};
    e.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return e;
  endfunction

  // Queue up the expected per-cycle outputs for one whole instruction
  task automatic modelStart(input logic [15:0] ir);
    exp_t b, e;
    logic [2:0] opc;
    logic [1:0] op;
    opc = ir[15:13];
    op  = ir[12:11];
    b   = idleOf(ir);
    b.w = 1'b0;
    if (opc == 3'b110 && op == 2'b10) begin
      q.push_back(b);
      e = b; e.writenum = ir[10:8]; e.vsel = 4'b0100; e.write = 1'b1; q.push_back(e);
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      q.push_back(b);
      if (opc == 3'b101 && op != 2'b11) begin
        e = b; e.readnum = ir[10:8]; e.loada = 1'b1; q.push_back(e);
      end
      e = b; e.readnum = ir[2:0]; e.loadb = 1'b1; q.push_back(e);
      e = b;
      if (opc == 3'b110) begin
        e.asel = 1'b1; e.aluop = 2'b00; e.loadc = 1'b1;
      end else begin
        e.aluop = op;
        if (op == 2'b01) e.loads = 1'b1;
        else             e.loadc = 1'b1;
      end
      q.push_back(e);
      if (!(opc == 3'b101 && op == 2'b01)) begin
        e = b; e.writenum = ir[7:5]; e.vsel = 4'b0001; e.write = 1'b1; q.push_back(e);
      end
    end else begin
      e = b; e.illegal = 1'b1; q.push_back(e);
    end
  endtask

  always @(negedge reset_n) begin
    q.delete();
    m_ir = '0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (q.size() > 0) void'(q.pop_front());
      else begin
        if (load_ir) m_ir = instr;
        if (s) modelStart(m_ir);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = (q.size() > 0) ? q[0] : idleOf(m_ir);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("[TB] FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act, e);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Issue one instruction, jam random load_ir/s while busy, and record what was seen
  task automatic applyStimulus(input logic [15:0] word, output int busy, output int writes,
                               output int ills, output int nloads, output logic [2:0] wn,
                               output logic [3:0] vs, output logic [15:0] sx8);
    busy = 0; writes = 0; ills = 0; nloads = 0; wn = '0; vs = '0; sx8 = '0;
    @(negedge clk);
    instr = word; load_ir = 1'b1; s = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (w) break;
      busy++;
      if (write) begin
        writes++; wn = writenum; vs = vsel; sx8 = sximm8;
      end
      if (illegal) ills++;
      if (loads) nloads++;
      instr   = 16'($urandom);
      load_ir = 1'($urandom_range(0, 1));
      s       = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    load_ir = 1'b0; s = 1'b0;
  endtask

  initial begin
    int busy, writes, ills, nloads;
    logic [2:0] wn;
    logic [3:0] vs;
    logic [15:0] sx8, r;
    logic [4:0] top;

    repeat (2) @(negedge clk);
    checkOutput("reset_w", 32'(w), 32'd1);
    checkOutput("reset_write", 32'(write), 32'd0);
    checkOutput("reset_sximm8", 32'(sximm8), 32'h0);
    reset_n = 1'b1;

    applyStimulus(16'hD107, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("movimm_busy", 32'(busy), 32'd2);
    checkOutput("movimm_writenum", 32'(wn), 32'd1);
    checkOutput("movimm_vsel", 32'(vs), 32'h4);
    checkOutput("movimm_sximm8", 32'(sx8), 32'h0007);

    applyStimulus(16'hD2F0, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("movneg_sximm8", 32'(sx8), 32'hFFF0);
    checkOutput("movneg_writenum", 32'(wn), 32'd2);

    applyStimulus(16'hA148, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("add_busy", 32'(busy), 32'd5);
    checkOutput("add_writenum", 32'(wn), 32'd2);
    checkOutput("add_vsel", 32'(vs), 32'h1);

    applyStimulus(16'hA900, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("cmp_busy", 32'(busy), 32'd4);
    checkOutput("cmp_writes", 32'(writes), 32'd0);
    checkOutput("cmp_loads", 32'(nloads), 32'd1);

    applyStimulus(16'hE000, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("illegal_busy", 32'(busy), 32'd1);
    checkOutput("illegal_pulses", 32'(ills), 32'd1);
    checkOutput("illegal_writes", 32'(writes), 32'd0);

    applyStimulus(16'hC800, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("movop01_illegal", 32'(ills), 32'd1);

    applyStimulus(16'hB860, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("mvn_busy", 32'(busy), 32'd4);
    checkOutput("mvn_writenum", 32'(wn), 32'd3);

    applyStimulus(16'hC041, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("movreg_busy", 32'(busy), 32'd4);
    checkOutput("movreg_writenum", 32'(wn), 32'd2);

    // Abort an ADD in GET_B with an asynchronous reset
    @(negedge clk);
    instr = 16'hA148; load_ir = 1'b1; s = 1'b1;
    @(negedge clk);
    load_ir = 1'b0; s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("getb_loadb", 32'(loadb), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_w", 32'(w), 32'd1);
    checkOutput("async_loadb", 32'(loadb), 32'd0);
    checkOutput("async_sximm5", 32'(sximm5), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(16'hD305, busy, writes, ills, nloads, wn, vs, sx8);
    checkOutput("postreset_busy", 32'(busy), 32'd2);
    checkOutput("postreset_writenum", 32'(wn), 32'd3);
    checkOutput("postreset_sximm8", 32'(sx8), 32'h0005);

    repeat (3000) begin
      @(negedge clk);
      r = 16'($urandom);
      case ($urandom_range(0, 6))
        0: top = 5'b11010;
        1: top = 5'b11000;
        2: top = 5'b10100;
        3: top = 5'b10101;
        4: top = 5'b10110;
        5: top = 5'b10111;
        default: top = r[15:11];
      endcase
      instr   = {top, r[10:0]};
      load_ir = 1'($urandom_range(0, 1));
      s       = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    load_ir = 1'b0; s = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
